// File: rtl/nice_csr_responder.sv
// -----------------------------------------------------------------------------
// nice_csr_responder
//
// Coprocessor-side target of the NICE CSR channel. It decodes CSR indices
// 0xE00-0xEFF and holds a small CSR bank (CTRL, STATUS, LAT, CYCLE, scratch).
// Writing go=1 to CTRL starts a timed BUSY run of max(LAT,1) cycles. While the
// run is active, ready stays low, which stalls the core's CSR instruction.
//
// Ports:
//   clk             clock
//   rst_n           synchronous active-low reset
//   nice_csr_valid  request valid (may drop without a handshake)
//   nice_csr_ready  responder ready (low while BUSY)
//   nice_csr_addr   CSR index, zero-extended 12-bit
//   nice_csr_wr     1 = write
//   nice_csr_wdata  write data
//   nice_csr_rdata  combinational read data (pre-write value)
//   nice_busy       engine in BUSY
//   nice_irq        STATUS.done & CTRL.ie
// -----------------------------------------------------------------------------
module nice_csr_responder #(
    parameter int          NREG    = 4,
    parameter logic [7:0]  LAT_RST = 8'd8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nice_csr_valid,
    output logic        nice_csr_ready,
    input  logic [31:0] nice_csr_addr,
    input  logic        nice_csr_wr,
    input  logic [31:0] nice_csr_wdata,
    output logic [31:0] nice_csr_rdata,
    output logic        nice_busy,
    output logic        nice_irq
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [4:0] NREG_W  = 5'(NREG);

    localparam logic [7:0] IDX_CTRL   = 8'h00;
    localparam logic [7:0] IDX_STATUS = 8'h01;
    localparam logic [7:0] IDX_LAT    = 8'h02;
    localparam logic [7:0] IDX_CYCLE  = 8'h03;

    logic [0:0]  state;
    logic [7:0]  cnt;
    logic [7:0]  lat;
    logic [7:0]  opcnt;
    logic        done;
    logic        ie;
    logic [31:0] cycle;
    // Sized for the maximum of 16 entries; entries at or above NREG are
    // never written, so they stay at zero and fold away in synthesis.
    logic [31:0] scratch [16];

    logic [7:0]  idx;
    logic        hit;
    logic        scr_hit;
    logic        xfer;
    logic        wr_xfer;
    logic        go;
    logic        finish;

    assign idx     = nice_csr_addr[7:0];
    assign hit     = (nice_csr_addr[31:12] == 20'd0) && (nice_csr_addr[11:8] == 4'hE);
    assign scr_hit = (idx[7:4] == 4'h1) && ({1'b0, idx[3:0]} < NREG_W);

    assign nice_csr_ready = (state == ST_IDLE);
    assign nice_busy      = (state == ST_BUSY);
    assign nice_irq       = done & ie;

    assign xfer    = nice_csr_valid & nice_csr_ready;
    assign wr_xfer = xfer & nice_csr_wr & hit;
    assign go      = wr_xfer && (idx == IDX_CTRL) && nice_csr_wdata[0];
    // Last BUSY cycle: the run ends on this edge.
    assign finish  = (state == ST_BUSY) && (cnt == 8'd1);

    // Read mux: a pure function of the index and current state, so a write
    // transfer shows the value held before its own commit.
    always_comb begin
        nice_csr_rdata = 32'd0;
        if (hit) begin
            case (idx)
                IDX_CTRL:   nice_csr_rdata = {30'd0, ie, 1'b0};
                IDX_STATUS: nice_csr_rdata = {16'd0, opcnt, 7'd0, done};
                IDX_LAT:    nice_csr_rdata = {24'd0, lat};
                IDX_CYCLE:  nice_csr_rdata = cycle;
                default: begin
                    if (scr_hit) begin
                        nice_csr_rdata = scratch[idx[3:0]];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
            lat   <= LAT_RST;
            opcnt <= 8'd0;
            done  <= 1'b0;
            ie    <= 1'b0;
            cycle <= 32'd0;
            for (int i = 0; i < 16; i++) begin
                scratch[i] <= 32'd0;
            end
        end else begin
            cycle <= cycle + 32'd1;

            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state <= ST_BUSY;
                        // LAT==0 still yields a one-cycle run.
                        cnt   <= (lat == 8'd0) ? 8'd1 : lat;
                    end
                end
                default: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state <= ST_IDLE;
                    end
                end
            endcase

            // Completion sets done; set wins over a W1C on the same edge.
            if (finish) begin
                done  <= 1'b1;
                opcnt <= opcnt + 8'd1;
            end else if (wr_xfer && (idx == IDX_STATUS) && nice_csr_wdata[0]) begin
                done <= 1'b0;
            end

            if (wr_xfer && (idx == IDX_CTRL)) begin
                ie <= nice_csr_wdata[1];
            end

            if (wr_xfer && (idx == IDX_LAT)) begin
                lat <= nice_csr_wdata[7:0];
            end

            if (wr_xfer && scr_hit) begin
                scratch[idx[3:0]] <= nice_csr_wdata;
            end
        end
    end

endmodule

// File: doc/nice_csr_responder.md
Name: nice_csr_responder

Overview:
- Coprocessor-side CSR target for the NICE CSR channel: the responder end of the nice_csr_valid/ready/addr/wr/wdata/rdata handshake driven by the core's CSR control path.
- Decodes CSR indices 0xE00–0xEFF and holds a small CSR bank: control, status, latency, a free-running cycle counter and scratch registers.
- Contains a timed BUSY engine. While the engine is busy the block deasserts ready, which stalls the core's CSR instruction.

Parameters:
- NREG, 4, number of 32-bit scratch CSRs at 0xE10..0xE10+NREG-1 (1..16).
- LAT_RST, 8, reset value of the LAT CSR (busy duration in cycles, 8 bits).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- nice_csr_valid  input  1  request valid. May drop without a handshake.
- nice_csr_ready  output  1  responder ready.
- nice_csr_addr  input  32  CSR index, zero-extended 12-bit.
- nice_csr_wr  input  1  1 = write the CSR.
- nice_csr_wdata  input  32  write data.
- nice_csr_rdata  output  32  read data, combinational, valid in the handshake cycle.
- nice_busy  output  1  engine in BUSY.
- nice_irq  output  1  STATUS.done & CTRL.ie.

Behaviour:
- One clock: clk. Reset is synchronous and active-low: rst_n sampled on the rising edge of clk.
- Transfer: occurs only on a cycle where nice_csr_valid & nice_csr_ready are both high.
  - No transfer when valid is low, whatever the other inputs are.
  - A request dropped while ready is low is not remembered.
- Select: hit = (addr[31:12]==0) & (addr[11:8]==4'hE). Decode is on addr[7:0].
  - Miss or unmapped index: rdata = 0 and the write is ignored.
  - ready is still governed by state, so a miss never hangs the core.
- rdata: pure function of addr and current register state. It is the pre-write value; the write commits at the clock edge ending the transfer.
- CSR map:
  - 0xE00 CTRL: bit0 go (write-1-to-start, always reads 0); bit1 ie (R/W); other bits read 0.
  - 0xE01 STATUS:
    - bit0 done (sticky, write-1-to-clear).
    - bits[15:8] opcnt (read-only, wraps 255→0).
    - Other bits read 0.
  - 0xE02 LAT: bits[7:0] R/W, reset LAT_RST.
  - 0xE03 CYCLE: 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF→0. Writes ignored.
  - 0xE10+i, i<NREG: scratch i, full 32-bit R/W, reset 0.
- State machine:
  - IDLE: ready=1, busy=0.
  - IDLE→BUSY: on a write transfer to CTRL with wdata[0]=1.
    - Load the down-counter with LAT; if LAT==0, load 1.
    - ie is updated by the same write.
  - BUSY: ready=0, busy=1, counter decrements every cycle.
  - BUSY→IDLE: on the edge where counter==1. On that same edge, done<=1 and opcnt<=opcnt+1.
  - BUSY therefore lasts exactly max(LAT,1) cycles. The first cycle with ready=1 again is the cycle after.
- Writes to LAT during BUSY are impossible because ready=0. The current run is never affected by LAT changes.
- done set vs W1C: these cannot coincide, since the setting edge ends a ready=0 cycle. Priority is nonetheless fixed as set wins.
- A write of CTRL with go=0 only updates ie.
- Reset values:
  - Outputs: ready=1, busy=0, irq=0, rdata=0 when the selected register is 0.
  - Registers: CYCLE=0, opcnt=0, done=0, ie=0, LAT=LAT_RST.
- Reset asserted mid-BUSY: on the next edge the state is IDLE and all state takes its reset value. The pending completion is lost: no done, no opcnt increment.

Test Plan:
- After reset: read 0xE02 → 0x08; read 0xE01 → 0; ready=1; read 0xE03 twice, 5 cycles apart → difference 5.
- Write 0xE11=0xDEADBEEF, then read → 0xDEADBEEF. In the write cycle, rdata shows the old value 0. Write to 0xE03 leaves CYCLE counting. Read 0xD00 or 0xE05 → 0, with no register changed.
- Write LAT=3, then CTRL=0x3 → ready=0 and busy=1 for exactly 3 cycles, valid held high throughout, no transfer. The stalled read of 0xE01 completes in cycle 4 → 0x0101. irq=1.
- Write STATUS=0x1 → done=0, irq=0, opcnt stays 1. Then LAT=0 and go → busy for exactly 1 cycle; STATUS → 0x0201.
- 256 go operations with LAT=1 → opcnt wraps to 0.
- rst_n low for one cycle mid-BUSY (LAT=10, cycle 4) → next cycle ready=1, busy=0, LAT=8, STATUS=0, irq=0.
